decode_pipe: RTL and testbench

Parametrised, handshaked RV32I decode stage. It sits between instruction fetch and register read/execute. It decodes all base-ISA instruction formats (R/I/S/B/U/J) into register addresses, a sign-extended XLEN immediate and ALU/writeback control. Results are held in a one-deep output pipeline register with valid/ready backpressure, flush and illegal-instruction flagging.

---
 rtl/decode_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// RV32I decode stage: combinational field/immediate/control decode feeding a
// one-deep valid/ready output register with flush and illegal flagging.
module decode_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned ALU_FN_W = 5
) (
    input  logic                clk,
    input  logic                nrst,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     out_pc,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_FN_W-1:0] alu_fn,
    output logic [1:0]          a_sel,
    output logic [1:0]          b_sel,
    output logic                we,
    output logic                pcselect,
    output logic                is_branch,
    output logic                illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_f;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign rd_f   = in_instr[11:7];

    // Format immediates, sign-extended from instr[31] through a signed size cast
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    // Decoded bundle (next value of the output register)
    logic [XLEN-1:0]     imm_d;
    logic [ALU_FN_W-1:0] alu_fn_d;
    logic [1:0]          a_sel_d;
    logic [1:0]          b_sel_d;
    logic                we_d;
    logic                pcselect_d;
    logic                is_branch_d;
    logic                illegal_d;

    // Opcode decode; illegal encodings collapse every control field to zero
    always_comb begin
        imm_d       = '0;
        alu_fn_d    = '0;
        a_sel_d     = A_RS1;
        b_sel_d     = B_RS2;
        we_d        = 1'b0;
        pcselect_d  = 1'b0;
        is_branch_d = 1'b0;
        illegal_d   = 1'b0;

        case (opcode)
            OPC_OP: begin
                alu_fn_d = ALU_FN_W'({1'b0, in_instr[30], funct3});
                we_d     = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_d    = imm_i;
                alu_fn_d = ALU_FN_W'({1'b0, (funct3 == 3'b101) & in_instr[30], funct3});
                b_sel_d  = B_IMM;
                we_d     = 1'b1;
            end
            OPC_LOAD: begin
                imm_d   = imm_i;
                b_sel_d = B_IMM;
                we_d    = 1'b1;
            end
            OPC_STORE: begin
                imm_d   = imm_s;
                b_sel_d = B_IMM;
            end
            OPC_BRANCH: begin
                imm_d       = imm_b;
                alu_fn_d    = ALU_FN_W'({2'b10, funct3});
                is_branch_d = 1'b1;
                illegal_d   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                imm_d      = imm_j;
                a_sel_d    = A_PC;
                b_sel_d    = B_IMM;
                pcselect_d = 1'b1;
                we_d       = 1'b1;
            end
            OPC_JALR: begin
                imm_d      = imm_i;
                b_sel_d    = B_IMM;
                pcselect_d = 1'b1;
                we_d       = 1'b1;
                illegal_d  = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                imm_d   = imm_u;
                a_sel_d = A_ZERO;
                b_sel_d = B_IMM;
                we_d    = 1'b1;
            end
            OPC_AUIPC: begin
                imm_d   = imm_u;
                a_sel_d = A_PC;
                b_sel_d = B_IMM;
                we_d    = 1'b1;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase

        // Compressed/non-32-bit encodings are unsupported
        if (in_instr[1:0] != 2'b11) begin
            illegal_d = 1'b1;
        end

        if (illegal_d) begin
            imm_d       = '0;
            alu_fn_d    = '0;
            a_sel_d     = A_RS1;
            b_sel_d     = B_RS2;
            we_d        = 1'b0;
            pcselect_d  = 1'b0;
            is_branch_d = 1'b0;
        end

        // x0 is never written
        if (rd_f == 5'd0) begin
            we_d = 1'b0;
        end
    end

    // Handshake
    logic out_valid_q;
    logic accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Output valid: flush wins, then refill, then pop
    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Output payload register, loaded only on accept
    logic [PC_W-1:0]     out_pc_q;
    logic [4:0]          rs1_q;
    logic [4:0]          rs2_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     imm_q;
    logic [ALU_FN_W-1:0] alu_fn_q;
    logic [1:0]          a_sel_q;
    logic [1:0]          b_sel_q;
    logic                we_q;
    logic                pcselect_q;
    logic                is_branch_q;
    logic                illegal_q;

    // Capture the decoded bundle on accept; hold otherwise
    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_pc_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_fn_q    <= '0;
            a_sel_q     <= '0;
            b_sel_q     <= '0;
            we_q        <= 1'b0;
            pcselect_q  <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_pc_q    <= in_pc;
            rs1_q       <= in_instr[19:15];
            rs2_q       <= in_instr[24:20];
            rd_q        <= rd_f;
            imm_q       <= imm_d;
            alu_fn_q    <= alu_fn_d;
            a_sel_q     <= a_sel_d;
            b_sel_q     <= b_sel_d;
            we_q        <= we_d;
            pcselect_q  <= pcselect_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign imm       = imm_q;
    assign alu_fn    = alu_fn_q;
    assign a_sel     = a_sel_q;
    assign b_sel     = b_sel_q;
    assign we        = we_q;
    assign pcselect  = pcselect_q;
    assign is_branch = is_branch_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed test-plan steps followed by random traffic,
// checked against an ISA-level reference decode and a one-entry holding model.
module tb_decode_pipe;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    // XLEN=32 instance
    logic        in_ready, out_valid, we, pcselect, is_branch, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1, rs2, rd, alu_fn;
    logic [1:0]  a_sel, b_sel;

    // XLEN=64, ALU_FN_W=7 instance
    logic        in_ready64, out_valid64, we64, pcselect64, is_branch64, illegal64;
    logic [31:0] out_pc64;
    logic [63:0] imm64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [6:0]  alu_fn64;
    logic [1:0]  a_sel64, b_sel64;

    decode_pipe #(.XLEN(32), .PC_W(32), .ALU_FN_W(5)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_fn(alu_fn),
        .a_sel(a_sel), .b_sel(b_sel), .we(we), .pcselect(pcselect),
        .is_branch(is_branch), .illegal(illegal)
    );

    decode_pipe #(.XLEN(64), .PC_W(32), .ALU_FN_W(7)) dut64 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm64), .alu_fn(alu_fn64),
        .a_sel(a_sel64), .b_sel(b_sel64), .we(we64), .pcselect(pcselect64),
        .is_branch(is_branch64), .illegal(illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic [4:0]  alu;
        logic [1:0]  a_sel, b_sel;
        logic        we, pcsel, br, ill;
    } exp_t;

    // Expected state of the stage: at most one held bundle
    logic        exp_valid;
    exp_t        exp_b;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two's-complement interpretation of a 'bits'-wide field
    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // ISA-level reference decode
    function automatic exp_t decode_ref(input logic [31:0] ins);
        exp_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e = '0;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin
                e.alu = {1'b0, ins[30], f3}; e.we = 1'b1;
            end
            7'b0010011: begin
                e.imm = 64'(sx(longint'(ins[31:20]), 12));
                e.alu = {1'b0, (f3 == 3'd5) && ins[30], f3};
                e.b_sel = 2'd1; e.we = 1'b1;
            end
            7'b0000011: begin
                e.imm = 64'(sx(longint'(ins[31:20]), 12));
                e.b_sel = 2'd1; e.we = 1'b1;
            end
            7'b0100011: begin
                e.imm = 64'(sx(longint'({ins[31:25], ins[11:7]}), 12));
                e.b_sel = 2'd1;
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
                else begin
                    e.imm = 64'(sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13));
                    e.br = 1'b1; e.alu = {2'b10, f3};
                end
            end
            7'b1101111: begin
                e.imm = 64'(sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21));
                e.pcsel = 1'b1; e.a_sel = 2'd1; e.b_sel = 2'd1; e.we = 1'b1;
            end
            7'b1100111: begin
                if (f3 != 3'd0) e.ill = 1'b1;
                else begin
                    e.imm = 64'(sx(longint'(ins[31:20]), 12));
                    e.pcsel = 1'b1; e.b_sel = 2'd1; e.we = 1'b1;
                end
            end
            7'b0110111: begin
                e.imm = 64'(sx(longint'({ins[31:12], 12'b0}), 32));
                e.a_sel = 2'd2; e.b_sel = 2'd1; e.we = 1'b1;
            end
            7'b0010111: begin
                e.imm = 64'(sx(longint'({ins[31:12], 12'b0}), 32));
                e.a_sel = 2'd1; e.b_sel = 2'd1; e.we = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("out_valid64", 64'(out_valid64), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", 64'(out_pc), 64'(exp_pc));
            chk("rs1", 64'(rs1), 64'(exp_b.rs1));
            chk("rs2", 64'(rs2), 64'(exp_b.rs2));
            chk("rd", 64'(rd), 64'(exp_b.rd));
            chk("alu_fn", 64'(alu_fn), 64'(exp_b.alu));
            chk("alu_fn64", 64'(alu_fn64), 64'(exp_b.alu));
            chk("a_sel", 64'(a_sel), 64'(exp_b.a_sel));
            chk("b_sel", 64'(b_sel), 64'(exp_b.b_sel));
            chk("we", 64'(we), 64'(exp_b.we));
            chk("pcselect", 64'(pcselect), 64'(exp_b.pcsel));
            chk("is_branch", 64'(is_branch), 64'(exp_b.br));
            chk("illegal", 64'(illegal), 64'(exp_b.ill));
            chk("illegal64", 64'(illegal64), 64'(exp_b.ill));
            if (!exp_b.ill) begin
                chk("imm", 64'(imm), 64'(exp_b.imm[31:0]));
                chk("imm64", imm64, exp_b.imm);
            end
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model, check outputs after posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic rdy);
        logic rdy_exp;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = rdy;
        #1;
        rdy_exp = !exp_valid || rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy_exp));
        chk("in_ready64", 64'(in_ready64), 64'(rdy_exp));
        if (fl) exp_valid = 1'b0;
        else if (v && rdy_exp) begin
            exp_valid = 1'b1; exp_b = decode_ref(ins); exp_pc = pc;
        end else if (rdy) exp_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert reset for one edge with busy inputs and expect every output cleared
    task automatic reset_check(input string tag);
        @(negedge clk);
        nrst = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_pc"}, 64'(out_pc), 64'd0);
        chk({tag, "_regs"}, 64'({rs1, rs2, rd}), 64'd0);
        chk({tag, "_imm"}, 64'(imm), 64'd0);
        chk({tag, "_imm64"}, imm64, 64'd0);
        chk({tag, "_ctrl"}, 64'({alu_fn, a_sel, b_sel, we, pcselect, is_branch, illegal}), 64'd0);
        chk({tag, "_ctrl64"}, 64'({out_valid64, alu_fn64, a_sel64, b_sel64, we64,
                                   pcselect64, is_branch64, illegal64}), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        nrst = 1'b1; in_valid = 1'b0;
    endtask

    logic [6:0] opc_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};

    initial begin
        logic [31:0] ins;
        nrst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        exp_valid = 1'b0; exp_b = '0; exp_pc = '0;
        reset_check("rst");

        // ADDI x1,x2,-1
        step(1'b1, 32'hFFF10093, 32'h100, 1'b0, 1'b1);
        chk("tp_addi_imm", 64'(imm), 64'hFFFF_FFFF);
        chk("tp_addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("tp_addi_we", 64'({rs1, rd, we}), 64'({5'd2, 5'd1, 1'b1}));

        // SUB then BEQ back-to-back
        step(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b1);
        chk("tp_sub_alu", 64'(alu_fn), 64'b01000);
        step(1'b1, 32'hFE000EE3, 32'h108, 1'b0, 1'b1);
        chk("tp_beq_imm", 64'(imm), 64'hFFFF_FFFC);
        chk("tp_beq_ctl", 64'({is_branch, alu_fn, we}), 64'({1'b1, 5'b10000, 1'b0}));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // LUI held for three cycles, pending ADDI accepted when ready returns
        step(1'b1, 32'h123452B7, 32'h200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00500113, 32'h204, 1'b0, 1'b0);
            chk("tp_lui_hold", 64'({imm, a_sel}), 64'({32'h12345000, 2'b10}));
        end
        step(1'b1, 32'h00500113, 32'h204, 1'b0, 1'b1);
        chk("tp_pending_pc", 64'(out_pc), 64'h204);

        // Flush kills the held and the presented instruction
        step(1'b1, 32'h402081B3, 32'h300, 1'b1, 1'b0);
        chk("tp_flush", 64'(out_valid), 64'd0);
        step(1'b1, 32'h402081B3, 32'h300, 1'b0, 1'b1);
        chk("tp_reissue_pc", 64'(out_pc), 64'h300);

        // Illegal zero word, then JAL x0,0
        step(1'b1, 32'h00000000, 32'h400, 1'b0, 1'b1);
        chk("tp_zero_ill", 64'({illegal, we}), 64'({1'b1, 1'b0}));
        step(1'b1, 32'h0000006F, 32'h404, 1'b0, 1'b1);
        chk("tp_jal_x0", 64'({pcselect, we, imm}), 64'({1'b1, 1'b0, 32'h0}));

        // Reset while holding a stalled bundle
        step(1'b1, 32'hFFF10093, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h00000013, 32'h504, 1'b1, 1'b0);
        step(1'b1, 32'hFFF10093, 32'h508, 1'b0, 1'b0);
        reset_check("midrst");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = opc_tab[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, ins, $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
